// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and constants for the 3x3 median pipeline
package median_pkg;

    localparam int PIXEL_WIDTH  = 8;
    localparam int KERNEL_SIZE  = 3;
    localparam int PIPE_LATENCY = 4;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef pixel_t [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1] window_t;

endpackage

// File: rtl/sort3.sv
// rtl/sort3.sv - three-input ascending sorter built from compare-exchange steps
module sort3 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] mid,
    output logic [WIDTH-1:0] max
);

    logic [WIDTH-1:0] lo_ab;
    logic [WIDTH-1:0] hi_ab;
    logic [WIDTH-1:0] lo_hc;

    // exchange a/b, then push the larger against c, then settle the two smaller ones
    always_comb begin
        lo_ab = (a < b) ? a : b;
        hi_ab = (a < b) ? b : a;
        lo_hc = (hi_ab < c) ? hi_ab : c;
        max   = (hi_ab < c) ? c : hi_ab;
        min   = (lo_ab < lo_hc) ? lo_ab : lo_hc;
        mid   = (lo_ab < lo_hc) ? lo_hc : lo_ab;
    end

endmodule

// File: rtl/axis_median_processing_3x3.sv
// rtl/axis_median_processing_3x3.sv - four-stage pipelined 3x3 median with aligned valid/sof
module axis_median_processing_3x3
    import median_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                                                     i_clk,
    input  logic                                                     i_aresetn,
    input  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] i_image_kernel_buffer,
    input  logic                                                     i_image_data_valid,
    input  logic                                                     i_start_of_frame,
    output logic [DATA_WIDTH-1:0]                                    o_median_pixel,
    output logic                                                     o_image_data_valid_reg,
    output logic                                                     o_start_of_frame_reg
);

    // [row][0]=min, [row][1]=mid, [row][2]=max after the row sort
    logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] row_sorted;
    logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] s1_q;
    // column sort result: [rank][col], rank 0 is the smallest of that column
    logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] col_sorted;
    logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] s2_q;
    logic [DATA_WIDTH-1:0]                                    s3_q;
    logic [PIPE_LATENCY-1:0]                                  valid_sr;
    logic [PIPE_LATENCY-1:0]                                  sof_sr;

    // median of three without building a full sorter
    function automatic logic [DATA_WIDTH-1:0] med3(
        input logic [DATA_WIDTH-1:0] x,
        input logic [DATA_WIDTH-1:0] y,
        input logic [DATA_WIDTH-1:0] z
    );
        logic [DATA_WIDTH-1:0] lo;
        logic [DATA_WIDTH-1:0] hi;
        logic [DATA_WIDTH-1:0] hz;
        lo = (x < y) ? x : y;
        hi = (x < y) ? y : x;
        hz = (hi < z) ? hi : z;
        return (lo < hz) ? hz : lo;
    endfunction

    genvar g;
    generate
        for (g = 0; g < KERNEL_SIZE; g++) begin : g_sort
            sort3 #(.WIDTH(DATA_WIDTH)) u_row (
                .a   (i_image_kernel_buffer[g][0]),
                .b   (i_image_kernel_buffer[g][1]),
                .c   (i_image_kernel_buffer[g][2]),
                .min (row_sorted[g][0]),
                .mid (row_sorted[g][1]),
                .max (row_sorted[g][2])
            );
            sort3 #(.WIDTH(DATA_WIDTH)) u_col (
                .a   (s1_q[0][g]),
                .b   (s1_q[1][g]),
                .c   (s1_q[2][g]),
                .min (col_sorted[0][g]),
                .mid (col_sorted[1][g]),
                .max (col_sorted[2][g])
            );
        end
    endgenerate

    // data pipeline: row sort, column sort, anti-diagonal median, output register
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            s1_q           <= '0;
            s2_q           <= '0;
            s3_q           <= '0;
            o_median_pixel <= '0;
        end else begin
            s1_q           <= row_sorted;
            s2_q           <= col_sorted;
            s3_q           <= med3(s2_q[0][2], s2_q[1][1], s2_q[2][0]);
            o_median_pixel <= s3_q;
        end
    end

    // sideband flags ride alongside the data, one bit per stage, never gated
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            valid_sr <= '0;
            sof_sr   <= '0;
        end else begin
            valid_sr <= {valid_sr[PIPE_LATENCY-2:0], i_image_data_valid};
            sof_sr   <= {sof_sr[PIPE_LATENCY-2:0], i_start_of_frame};
        end
    end

    assign o_image_data_valid_reg = valid_sr[PIPE_LATENCY-1];
    assign o_start_of_frame_reg   = sof_sr[PIPE_LATENCY-1];

endmodule

// File: tb/tb_axis_median_processing_3x3.sv
// tb/tb_axis_median_processing_3x3.sv - scoreboard bench for the 3x3 median pipeline
module tb_axis_median_processing_3x3;
    import median_pkg::*;

    logic    clk = 1'b0;
    logic    aresetn = 1'b1;
    window_t win = '0;
    logic    vin = 1'b0;
    logic    sof = 1'b0;
    logic [7:0] med;
    logic    vout;
    logic    sout;

    always #5 clk = ~clk;

    axis_median_processing_3x3 #(.DATA_WIDTH(8), .KERNEL_SIZE(3)) dut (
        .i_clk                  (clk),
        .i_aresetn              (aresetn),
        .i_image_kernel_buffer  (win),
        .i_image_data_valid     (vin),
        .i_start_of_frame       (sof),
        .o_median_pixel         (med),
        .o_image_data_valid_reg (vout),
        .o_start_of_frame_reg   (sout)
    );

    typedef struct {
        logic [7:0] pix;
        logic       v;
        logic       s;
        logic       chk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [7:0] sw_median(input window_t w);
        logic [7:0] v[9];
        logic [7:0] t;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[i*3+j] = w[i][j];
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return v[4];
    endfunction

    function automatic window_t rand_win();
        window_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    // one clock: compare the output due now, then drive the next window
    task automatic step(input window_t w, input logic v, input logic s);
        exp_t e;
        @(negedge clk);
        e = sb.pop_front();
        check("valid", {31'd0, vout}, {31'd0, e.v});
        check("sof", {31'd0, sout}, {31'd0, e.s});
        if (e.chk) check("pixel", {24'd0, med}, {24'd0, e.pix});
        win = w;
        vin = v;
        sof = s;
        e.pix = sw_median(w);
        e.v   = v;
        e.s   = s;
        e.chk = v;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pixel"}, {24'd0, med}, 32'd0);
        check({tag, "_valid"}, {31'd0, vout}, 32'd0);
        check({tag, "_sof"}, {31'd0, sout}, 32'd0);
    endtask

    // reset held for n+1 cycles with random inputs; pipeline restarts from zeros
    task automatic do_reset(input int n);
        exp_t e;
        @(negedge clk);
        aresetn = 1'b0;
        win = rand_win();
        vin = 1'b1;
        sof = 1'b1;
        #1 check_zero("rst_assert");
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            win = rand_win();
            vin = 1'($urandom_range(0, 1));
            sof = 1'($urandom_range(0, 1));
            #1 check_zero("rst_hold");
        end
        @(negedge clk);
        check_zero("rst_release");
        win = '0;
        vin = 1'b0;
        sof = 1'b0;
        aresetn = 1'b1;
        sb.delete();
        e.pix = 8'd0; e.v = 1'b0; e.s = 1'b0; e.chk = 1'b1;
        repeat (3) sb.push_back(e);
        e.chk = 1'b0;
        sb.push_back(e);
    endtask

    window_t ref_w;
    window_t w;

    initial begin
        do_reset(3);
        repeat (3) step('0, 1'b0, 1'b0);

        ref_w = {8'd2, 8'd4, 8'd9, 8'd7, 8'd1, 8'd3, 8'd5, 8'd8, 8'd6};
        step(ref_w, 1'b1, 1'b1);
        repeat (7) step('0, 1'b0, 1'b0);

        w = '1;
        step(w, 1'b1, 1'b0);
        w = {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        step(w, 1'b1, 1'b0);
        w = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
        step(w, 1'b1, 1'b0);
        w = '0;
        step(w, 1'b1, 1'b0);
        repeat (5) step('0, 1'b0, 1'b0);

        for (int k = 0; k < 40; k++)
            step(rand_win(), 1'b1, (k == 0));
        repeat (5) step(rand_win(), 1'b0, 1'b0);

        repeat (3) step(rand_win(), 1'b1, 1'b0);
        do_reset(0);
        repeat (4) step(rand_win(), 1'b0, 1'b0);
        step(ref_w, 1'b1, 1'b0);
        repeat (5) step('0, 1'b0, 1'b0);

        step(rand_win(), 1'b0, 1'b1);
        step(rand_win(), 1'b1, 1'b0);
        repeat (6) step(rand_win(), 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
